// File: rtl/pocket_bridge_spi_tgt.sv
`timescale 1ns/1ps
// pocket_bridge_spi_tgt
//   Core-side target of the Pocket bridge SPI link. The bridge initiates
//   frames with an active-low select and clocks two data lines (a dibit per
//   SPI clock, LSB first). A frame carries a 32-bit address word
//   (bit0=1 write, bit0=0 read) followed by 32 bits of write data in, or
//   32 bits of read data out on the same two lines.
//
//   Optional feature (macro POCKET_SPI_TIMEOUT_EN): a stalled spiclk with
//   spiss low for TIMEOUT clk cycles aborts the frame (err=1, parked in DONE
//   until spiss rises). Without the macro a stall holds the state forever.
//
// Ports
//   clk      system clock, >= 8x the SPI clock
//   rst_n    asynchronous active-low reset
//   spiclk   bridge SPI clock (async, idles low)
//   spiss    slave select, active low (async)
//   din      {miso,mosi} pad inputs
//   dout     {miso,mosi} pad outputs
//   dout_oe  output enable for both pads
//   addr     last decoded address word (bit0 = R/W flag)
//   wdata    last write data word
//   wr       one-cycle write strobe
//   rd       one-cycle read request
//   rdata    read data from the core
//   rd_ack   rdata valid (may be tied high)
//   err      sticky error flag, cleared at the next frame start
module pocket_bridge_spi_tgt #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spiclk,
  input  logic        spiss,
  input  logic [1:0]  din,
  output logic [1:0]  dout,
  output logic        dout_oe,
  output logic [31:0] addr,
  output logic [31:0] wdata,
  output logic        wr,
  output logic        rd,
  input  logic [31:0] rdata,
  input  logic        rd_ack,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WDATA,
    S_RWAIT,
    S_RDATA,
    S_DONE
  } state_t;

  // Synchronisers: newest sample enters bit 0, last stage is the MSB.
  logic [SYNC_STAGES-1:0]      r_clk_sync;
  logic [SYNC_STAGES-1:0]      r_ss_sync;
  logic [SYNC_STAGES-1:0][1:0] r_din_sync;
  logic                        r_clk_d;

  logic       w_clk;
  logic       w_ss;
  logic [1:0] w_din;
  logic       w_rise;
  logic       w_fall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_ss_sync  <= '1;
      r_din_sync <= '0;
      r_clk_d    <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], spiclk};
      r_ss_sync  <= {r_ss_sync[SYNC_STAGES-2:0], spiss};
      r_din_sync <= {r_din_sync[SYNC_STAGES-2:0], din};
      r_clk_d    <= w_clk;
    end
  end

  assign w_clk  = r_clk_sync[SYNC_STAGES-1];
  assign w_ss   = r_ss_sync[SYNC_STAGES-1];
  assign w_din  = r_din_sync[SYNC_STAGES-1];
  assign w_rise = w_clk & ~r_clk_d;
  assign w_fall = ~w_clk & r_clk_d;

  // Frame state and datapath registers
  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [29:0] r_shift;   // upper 30 bits of the receive shifter
  logic [29:0] r_oshift;  // read dibits not yet presented on dout
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_wr;
  logic        r_rd;
  logic        r_err;
  logic [1:0]  r_dout;
  logic        r_oe;
  logic        r_skip;    // first fall after rd_ack keeps dibit 0 on the pads
  logic        r_armed;   // spiss seen high since reset

  state_t      w_state_nxt;
  logic [3:0]  w_cnt_nxt;
  logic [29:0] w_shift_nxt;
  logic [29:0] w_oshift_nxt;
  logic [31:0] w_addr_nxt;
  logic [31:0] w_wdata_nxt;
  logic        w_wr_nxt;
  logic        w_rd_nxt;
  logic        w_err_nxt;
  logic [1:0]  w_dout_nxt;
  logic        w_oe_nxt;
  logic        w_skip_nxt;

  logic [31:0] w_sample;
  logic        w_tmo_hit;

  // New dibit enters at [31:30]; after 16 samples the first dibit is at [1:0].
  assign w_sample = {w_din, r_shift};

`ifdef POCKET_SPI_TIMEOUT_EN
  localparam logic [11:0] TMO_LIMIT = 12'(TIMEOUT);

  logic [11:0] r_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo <= '0;
    end else if (w_rise || w_fall || w_ss || r_state == S_IDLE || r_state == S_DONE) begin
      r_tmo <= '0;
    end else if (r_tmo != TMO_LIMIT) begin
      r_tmo <= r_tmo + 12'd1;
    end
  end

  // A spiss-high abort or a real edge in the same cycle takes precedence.
  assign w_tmo_hit = (r_tmo == TMO_LIMIT) && !w_rise && !w_fall && !w_ss;
`else
  // No stall detection: TIMEOUT is referenced only to keep it in the interface.
  assign w_tmo_hit = 1'b0 & (TIMEOUT != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_shift_nxt  = r_shift;
    w_oshift_nxt = r_oshift;
    w_addr_nxt   = r_addr;
    w_wdata_nxt  = r_wdata;
    w_wr_nxt     = 1'b0;
    w_rd_nxt     = 1'b0;
    w_err_nxt    = r_err;
    w_dout_nxt   = r_dout;
    w_oe_nxt     = r_oe;
    w_skip_nxt   = r_skip;

    case (r_state)
      S_IDLE: begin
        w_oe_nxt   = 1'b0;
        w_dout_nxt = 2'b00;
        if (r_armed && !w_ss) begin
          w_state_nxt = S_ADDR;
          w_cnt_nxt   = '0;
          w_shift_nxt = '0;
          w_err_nxt   = 1'b0;
        end
      end

      S_ADDR: begin
        if (w_ss) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_rise) begin
          w_shift_nxt = w_sample[31:2];
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_addr_nxt = w_sample;
            w_cnt_nxt  = '0;
            if (w_sample[0]) begin
              w_state_nxt = S_WDATA;
            end else begin
              w_state_nxt = S_RWAIT;
              w_rd_nxt    = 1'b1;
            end
          end
        end
      end

      S_WDATA: begin
        // Abort is checked first so a final rise coinciding with spiss
        // rising is discarded without a write strobe.
        if (w_ss) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_rise) begin
          w_shift_nxt = w_sample[31:2];
          w_cnt_nxt   = r_cnt + 4'd1;
          if (r_cnt == 4'd15) begin
            w_wdata_nxt = w_sample;
            w_wr_nxt    = 1'b1;
            w_state_nxt = S_DONE;
          end
        end
      end

      S_RWAIT: begin
        if (w_ss) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (rd_ack) begin
          w_oshift_nxt = rdata[31:2];
          w_dout_nxt   = rdata[1:0];
          w_oe_nxt     = 1'b1;
          w_skip_nxt   = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_RDATA;
        end else if (w_fall) begin
          // Core too slow: this fall is the one that should have exposed
          // dibit 0, so send zeros and flag the frame.
          w_oshift_nxt = '0;
          w_dout_nxt   = 2'b00;
          w_oe_nxt     = 1'b1;
          w_skip_nxt   = 1'b0;
          w_err_nxt    = 1'b1;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_RDATA;
        end
      end

      S_RDATA: begin
        if (w_ss) begin
          w_state_nxt = S_IDLE;
          w_err_nxt   = 1'b1;
        end else if (w_fall) begin
          if (r_skip) begin
            w_skip_nxt = 1'b0;
          end else if (r_cnt == 4'd15) begin
            w_oe_nxt    = 1'b0;
            w_state_nxt = S_DONE;
          end else begin
            w_dout_nxt   = r_oshift[1:0];
            w_oshift_nxt = {2'b00, r_oshift[29:2]};
            w_cnt_nxt    = r_cnt + 4'd1;
          end
        end
      end

      S_DONE: begin
        w_oe_nxt = 1'b0;
        if (w_ss) begin
          w_state_nxt = S_IDLE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_oe_nxt    = 1'b0;
      end
    endcase

    // Any abort path leaves the pads released and no strobe pending.
    if (w_state_nxt == S_IDLE && r_state != S_IDLE) begin
      w_oe_nxt   = 1'b0;
      w_dout_nxt = 2'b00;
    end

    if (w_tmo_hit && r_state != S_IDLE && r_state != S_DONE) begin
      w_state_nxt = S_DONE;
      w_err_nxt   = 1'b1;
      w_oe_nxt    = 1'b0;
      w_dout_nxt  = 2'b00;
      w_wr_nxt    = 1'b0;
      w_rd_nxt    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_shift  <= '0;
      r_oshift <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wr     <= 1'b0;
      r_rd     <= 1'b0;
      r_err    <= 1'b0;
      r_dout   <= '0;
      r_oe     <= 1'b0;
      r_skip   <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_shift  <= w_shift_nxt;
      r_oshift <= w_oshift_nxt;
      r_addr   <= w_addr_nxt;
      r_wdata  <= w_wdata_nxt;
      r_wr     <= w_wr_nxt;
      r_rd     <= w_rd_nxt;
      r_err    <= w_err_nxt;
      r_dout   <= w_dout_nxt;
      r_oe     <= w_oe_nxt;
      r_skip   <= w_skip_nxt;
      if (w_ss) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign dout    = r_dout;
  assign dout_oe = r_oe;
  assign addr    = r_addr;
  assign wdata   = r_wdata;
  assign wr      = r_wr;
  assign rd      = r_rd;
  assign err     = r_err;

endmodule

// File: tb/tb_pocket_bridge_spi_tgt.sv
`timescale 1ns/1ps
module tb_pocket_bridge_spi_tgt;

  localparam int T = 500;  // SPI half period in ns (1 MHz)

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        spiclk = 1'b0;
  logic        spiss = 1'b1;
  logic [1:0]  din = 2'b00;
  logic [1:0]  dout;
  logic        dout_oe;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wr;
  logic        rd;
  logic [31:0] rdata = 32'h0;
  logic        rd_ack = 1'b1;
  logic        err;

  always #10 clk = ~clk;

  pocket_bridge_spi_tgt #(
    .SYNC_STAGES(2),
    .TIMEOUT    (100)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .spiclk (spiclk),
    .spiss  (spiss),
    .din    (din),
    .dout   (dout),
    .dout_oe(dout_oe),
    .addr   (addr),
    .wdata  (wdata),
    .wr     (wr),
    .rd     (rd),
    .rdata  (rdata),
    .rd_ack (rd_ack),
    .err    (err)
  );

  typedef struct packed {
    logic        is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } bus_t;

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } rx_t;

  bus_t exp_bus[$];
  rx_t  exp_rx[$];
  rx_t  got_rx;
  event ev_rx;

  int n_checks = 0;
  int n_err    = 0;
  bit in_write = 1'b0;
  int oe_in_write = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus monitor: every wr/rd strobe must match the next expected transaction.
  initial begin
    bus_t e;
    forever begin
      @(negedge clk);
      if (in_write && dout_oe) oe_in_write++;
      if (wr || rd) begin
        check("wr_rd_exclusive", 32'(wr & rd), 32'h0);
        if (exp_bus.size() == 0) begin
          check("unexpected_strobe", {30'h0, wr, rd}, 32'h0);
        end else begin
          e = exp_bus.pop_front();
          check("strobe_kind", 32'(wr), 32'(e.is_wr));
          check("strobe_addr", addr, e.addr);
          if (e.is_wr) check("strobe_wdata", wdata, e.data);
        end
      end
    end
  end

  // Read-data monitor: words captured off the pads by the SPI driver.
  initial begin
    rx_t e;
    forever begin
      @(ev_rx);
      if (exp_rx.size() == 0) begin
        check("unexpected_rx", got_rx.data, 32'h0);
      end else begin
        e = exp_rx.pop_front();
        check("rx_data", got_rx.data, e.data);
        check("rx_err", 32'(got_rx.err), 32'(e.err));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // Bridge-side dibit shifter: present tx dibit, sample dout before the rise.
  task automatic shift_dibits(input logic [31:0] tx, input int unsigned n, output logic [31:0] rx);
    rx = '0;
    for (int unsigned i = 0; i < n; i++) begin
      din = tx[2*i +: 2];
      #(T);
      rx[2*i +: 2] = dout;
      spiclk = 1'b1;
      #(T);
      spiclk = 1'b0;
    end
  endtask

  task automatic write_frame(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] junk;
    exp_bus.push_back('{is_wr: 1'b1, addr: a, data: d});
    in_write = 1'b1;
    spiss = 1'b0;
    #(T);
    shift_dibits(a, 16, junk);
    shift_dibits(d, 16, junk);
    #(T);
    spiss = 1'b1;
    in_write = 1'b0;
    #(4*T);
  endtask

  task automatic read_frame(input logic [31:0] a, input logic [31:0] core_data, input logic ack,
                            input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] junk;
    logic [31:0] rx;
    rdata  = core_data;
    rd_ack = ack;
    exp_bus.push_back('{is_wr: 1'b0, addr: a, data: 32'h0});
    exp_rx.push_back('{data: exp_data, err: exp_err});
    spiss = 1'b0;
    #(T);
    shift_dibits(a, 16, junk);
    shift_dibits(32'h0, 16, rx);
    #(T);
    got_rx = '{data: rx, err: err};
    -> ev_rx;
    check("oe_after_read", 32'(dout_oe), 32'h0);
    spiss  = 1'b1;
    rd_ack = 1'b1;
    #(4*T);
  endtask

  initial begin
    logic [31:0] junk;

    // Reset values while rst_n is low
    #43;
    check("rst_dout", 32'(dout), 32'h0);
    check("rst_oe", 32'(dout_oe), 32'h0);
    check("rst_wr", 32'(wr), 32'h0);
    check("rst_rd", 32'(rd), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_addr", addr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    #60;
    rst_n = 1'b1;
    #100;

    // Write
    write_frame(32'h0000_1005, 32'hCAFE_F00D);
    check("wr_addr", addr, 32'h0000_1005);
    check("wr_wdata", wdata, 32'hCAFE_F00D);
    check("wr_err", 32'(err), 32'h0);
    check("oe_during_write", 32'(oe_in_write), 32'h0);

    // Read with combinational ack
    read_frame(32'hF800_0000, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0);
    check("rd_err", 32'(err), 32'h0);

    // Read with the ack held off past the first fall: zeros and err
    read_frame(32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1'b1);
    check("late_ack_err", 32'(err), 32'h1);

    // Abort after 10 address dibits, then a clean write clears err
    spiss = 1'b0;
    #(T);
    shift_dibits(32'h0000_1005, 10, junk);
    spiss = 1'b1;
    #(400);
    check("abort_err", 32'(err), 32'h1);
    check("abort_oe", 32'(dout_oe), 32'h0);
    #(4*T);
    write_frame(32'h0000_0021, 32'h0BAD_F00D);
    check("post_abort_err", 32'(err), 32'h0);
    check("post_abort_wdata", wdata, 32'h0BAD_F00D);

    // Reset asserted during RDATA
    rdata  = 32'hA5A5_3C3C;
    rd_ack = 1'b1;
    exp_bus.push_back('{is_wr: 1'b0, addr: 32'h0000_0200, data: 32'h0});
    spiss = 1'b0;
    #(T);
    shift_dibits(32'h0000_0200, 16, junk);
    shift_dibits(32'h0, 5, junk);
    #(200);
    check("pre_rst_oe", 32'(dout_oe), 32'h1);
    rst_n = 1'b0;
    #15;
    check("mid_rst_oe", 32'(dout_oe), 32'h0);
    check("mid_rst_addr", addr, 32'h0);
    spiss = 1'b1;
    #100;
    rst_n = 1'b1;
    #(4*T);
    read_frame(32'h0000_0300, 32'h0F1E_2D3C, 1'b1, 32'h0F1E_2D3C, 1'b0);
    check("post_rst_err", 32'(err), 32'h0);

    // spiclk frozen mid-address with spiss low
`ifndef POCKET_SPI_TIMEOUT_EN
    exp_bus.push_back('{is_wr: 1'b1, addr: 32'h0000_0045, data: 32'h1357_9BDF});
`endif
    spiss = 1'b0;
    #(T);
    shift_dibits(32'h0000_0045, 6, junk);
    #(3000);
`ifdef POCKET_SPI_TIMEOUT_EN
    check("stall_err", 32'(err), 32'h1);
`else
    check("stall_err", 32'(err), 32'h0);
`endif
    shift_dibits(32'h0000_0045 >> 12, 10, junk);
    shift_dibits(32'h1357_9BDF, 16, junk);
    #(T);
`ifdef POCKET_SPI_TIMEOUT_EN
    check("stall_end_err", 32'(err), 32'h1);
`else
    check("stall_end_err", 32'(err), 32'h0);
    check("stall_wdata", wdata, 32'h1357_9BDF);
`endif
    spiss = 1'b1;
    #(4*T);

    check("bus_queue_empty", 32'(exp_bus.size()), 32'h0);
    check("rx_queue_empty", 32'(exp_rx.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
